// File: rtl/fifo_thresh.sv
// rtl/fifo_thresh.sv - single-clock FIFO with occupancy count, thresholds, error pulses and optional FWFT
//
// Parameters: WIDTH data bits, DEPTH entries (power of two), AFULL_THRESH / AEMPTY_THRESH
// flag thresholds, FWFT (0 = registered read, 1 = first-word-fall-through).
// Optional macro FIFO_FLUSH_EN adds the synchronous flush input.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            (FIFO_FLUSH_EN only) clears pointers and count on the next edge
//   wr_en, data_in   write request and data; ignored while full
//   rd_en            read/pop request; ignored while empty
//   data_out         read data (registered, or head-of-queue when FWFT=1)
//   empty, full      occupancy at 0 / DEPTH
//   almost_empty     count <= AEMPTY_THRESH
//   almost_full      count >= AFULL_THRESH
//   count            occupancy 0..DEPTH
//   overflow         one-cycle pulse after a write attempted while full
//   underflow        one-cycle pulse after a read attempted while empty

module fifo_thresh #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 8,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 1,
   parameter int FWFT          = 0
) (
   input  logic                     clk,
   input  logic                     rst,
`ifdef FIFO_FLUSH_EN
   input  logic                     flush,
`endif
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [WIDTH-1:0]         data_in,
   output logic [WIDTH-1:0]         data_out,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             flush_req;
   logic             wr_ok;
   logic             rd_ok;

`ifdef FIFO_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // Flags come straight from the registered count, so they move on the same edge as count.
   assign empty        = (count == '0);
   assign full         = (count == FULL_CNT);
   assign almost_empty = (count <= AE_CNT);
   assign almost_full  = (count >= AF_CNT);

   // Acceptance uses pre-edge full/empty: a pop in the same cycle does not make room for a write.
   assign wr_ok = wr_en && !full  && !flush_req;
   assign rd_ok = rd_en && !empty && !flush_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush_req) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         if (wr_ok && !rd_ok)
            count <= count + CW'(1);
         else if (rd_ok && !wr_ok)
            count <= count - CW'(1);
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head of queue is visible whenever something is stored.
         assign data_out = empty ? '0 : mem[rd_ptr];
      end else begin : g_reg
         // Holds its last value on idle cycles, underflow and flush.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               data_out <= '0;
            else if (rd_ok)
               data_out <= mem[rd_ptr];
         end
      end
   endgenerate

endmodule

// File: tb/tb_fifo_thresh.sv
// tb/tb_fifo_thresh.sv - randomized and directed bench for fifo_thresh against a queue model
//
// Drives one registered-read instance and one FWFT instance with identical stimulus.
// Optional macro FIFO_FLUSH_EN enables the flush port and flush scenarios.

module tb_fifo_thresh;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AFT   = 6;
   localparam int AET   = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic             rd_en;
   logic             flush;
   logic [WIDTH-1:0] data_in;

   logic [WIDTH-1:0] dout_r,  dout_f;
   logic             empty_r, empty_f, full_r, full_f;
   logic             ae_r, ae_f, af_r, af_f;
   logic [3:0]       count_r, count_f;
   logic             ovf_r, ovf_f, udf_r, udf_f;

   int checks   = 0;
   int failures = 0;

   // Reference model: a plain queue of stored words plus the expected registered read value.
   logic [WIDTH-1:0] q [$];
   logic [WIDTH-1:0] m_dout;
   bit               m_ovf;
   bit               m_udf;

   always #5 clk = ~clk;

   fifo_thresh #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET), .FWFT(0)) u_reg (
      .clk(clk), .rst(rst),
`ifdef FIFO_FLUSH_EN
      .flush(flush),
`endif
      .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(dout_r),
      .empty(empty_r), .full(full_r), .almost_empty(ae_r), .almost_full(af_r),
      .count(count_r), .overflow(ovf_r), .underflow(udf_r)
   );

   fifo_thresh #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst),
`ifdef FIFO_FLUSH_EN
      .flush(flush),
`endif
      .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(dout_f),
      .empty(empty_f), .full(full_f), .almost_empty(ae_f), .almost_full(af_f),
      .count(count_f), .overflow(ovf_f), .underflow(udf_f)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_all();
      int n;
      int head;
      n    = q.size();
      head = (n > 0) ? int'(q[0]) : 0;
      check("count",        int'(count_r), n);
      check("empty",        int'(empty_r), int'(n == 0));
      check("full",         int'(full_r),  int'(n == DEPTH));
      check("almost_empty", int'(ae_r),    int'(n <= AET));
      check("almost_full",  int'(af_r),    int'(n >= AFT));
      check("overflow",     int'(ovf_r),   int'(m_ovf));
      check("underflow",    int'(udf_r),   int'(m_udf));
      check("data_out_reg", int'(dout_r),  int'(m_dout));
      check("data_out_fwft", int'(dout_f), head);
      check("count_fwft",   int'(count_f), n);
      check("empty_fwft",   int'(empty_f), int'(n == 0));
      check("flags_fwft",   int'({full_f, ae_f, af_f, ovf_f, udf_f}),
            int'({n == DEPTH, n <= AET, n >= AFT, m_ovf, m_udf}));
   endtask

   task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit f);
      bit fl;
      bit was_full;
      bit was_empty;
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      flush   = f;
      fl      = f;
`ifndef FIFO_FLUSH_EN
      fl = 1'b0;
`endif
      @(posedge clk);
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (fl) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         m_ovf = w && was_full;
         m_udf = r && was_empty;
         if (r && !was_empty) m_dout = q.pop_front();
         if (w && !was_full)  q.push_back(d);
      end
      #1;
      check_all();
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; data_in = '0;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset mid-operation, checked before any clock edge.
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #2;
      rst = 1'b0;
      step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Fill past full, then drain past empty.
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
      step(1'b1, 1'b0, 8'hAA, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Pointer wrap, simultaneous read/write at mid occupancy and at full.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hE0 + i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
      step(1'b1, 1'b1, 8'h24, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
      step(1'b1, 1'b1, 8'h99, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

      // Single word through an empty FIFO (fall-through visibility on the FWFT instance).
      step(1'b1, 1'b0, 8'h3C, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);

`ifdef FIFO_FLUSH_EN
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b1);
      step(1'b1, 1'b0, 8'h55, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b1);
`endif

      // Randomized phases: fill-biased, drain-biased, balanced.
      for (int ph = 0; ph < 3; ph++) begin
         int pw;
         int pr;
         pw = (ph == 0) ? 80 : (ph == 1) ? 30 : 50;
         pr = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
         for (int i = 0; i < 200; i++) begin
            bit w;
            bit r;
            bit f;
            w = ($urandom_range(0, 99) < pw);
            r = ($urandom_range(0, 99) < pr);
            f = ($urandom_range(0, 31) == 0);
`ifndef FIFO_FLUSH_EN
            f = 1'b0;
`endif
            step(w, r, 8'($urandom), f);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
